seg7_seq_monitor: RTL and testbench
===================================

SEG7_SEQ_MONITOR -- requirements
Module: seg7_seq_monitor

Interface
REQ-001 SHALL have parameter STABLE_N, default 2, meaning consecutive identical samples required before a value is accepted (range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sample_en  input  1  sample strobe; inputs are examined only in cycles where it is high.
REQ-005 SHALL have port seg_tens  input  7  tens-digit segment pattern, bit6..0 = g..a, active-high.
REQ-006 SHALL have port seg_ones  input  7  ones-digit segment pattern, same encoding.
REQ-007 SHALL have port valid_o  output  1  one-cycle pulse marking a newly accepted legal value.
REQ-008 SHALL have port tens_o  output  4  BCD tens digit of the last accepted legal value.
REQ-009 SHALL have port ones_o  output  4  BCD ones digit of the last accepted legal value.
REQ-010 SHALL have port pat_err  output  1  one-cycle pulse for an accepted value containing an illegal pattern.
REQ-011 SHALL have port seq_err  output  1  one-cycle pulse for an out-of-sequence value while locked.
REQ-012 SHALL have port locked  output  1  high while the FSM is in LOCKED.
REQ-013 SHALL have port err_cnt  output  8  saturating count of pat_err plus seq_err events.

Function
REQ-014 SHALL decode these legal patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; any other pattern is illegal.
REQ-015 SHALL register {seg_tens,seg_ones} on each sample_en cycle and compare it with the previous sample.
REQ-016 SHALL set the stability count to min(count+1, STABLE_N) if the sample equals the previous one, else to 1.
REQ-017 SHALL accept a sample when the stability count reaches STABLE_N and the raw 14-bit sample differs from the last accepted sample, or no sample has been accepted since reset.
REQ-018 SHALL never re-accept a held value: a sample equal to the last accepted sample produces no pulse.
REQ-019 SHALL assert valid_o, pat_err or seq_err in the cycle after the accepting sample_en cycle (latency 1 from acceptance), and SHALL update tens_o/ones_o in that same cycle.
REQ-020 SHALL, on an accepted illegal value, pulse pat_err, leave tens_o/ones_o and valid_o unchanged/low, and move to UNLOCKED.
REQ-021 SHALL, on an accepted legal value, pulse valid_o and update tens_o/ones_o in every FSM state, including when seq_err also pulses.
REQ-022 SHALL compute expected = BCD successor of the last legal value: ones 9 -> 0 with tens+1; 99 -> 01; 00 is never an expected value.
REQ-023 SHALL implement FSM states UNLOCKED, ACQUIRE and LOCKED with these transitions on accepted legal values:
- UNLOCKED -> ACQUIRE.
- ACQUIRE -> LOCKED if value == expected; otherwise stay in ACQUIRE, with no error.
- LOCKED -> LOCKED if value == expected; otherwise seq_err and -> ACQUIRE.
REQ-024 SHALL reload expected from every accepted legal value.
REQ-025 SHALL increment err_cnt once per pat_err or seq_err pulse, saturating at 255; the two pulses are mutually exclusive.
REQ-026 SHALL hold all state, with all pulses low, in cycles where sample_en is low.

Reset
REQ-027 SHALL, while rst is high, force valid_o=0, pat_err=0, seq_err=0, locked=0, tens_o=0, ones_o=0, err_cnt=0, stability count 0, the no-accepted-yet flag set, and state UNLOCKED.
REQ-028 SHALL treat rst asserted mid-operation identically: the sample history is discarded and no pulse is emitted in the cycle after deassertion.

Structure
REQ-029 SHALL take the segment pattern constants, the FSM state type and the STABLE_N range limits from shared package seg7_pkg.
REQ-030 SHALL use one combinational sub-module, seg7_decode (7-bit pattern -> 4-bit digit plus illegal flag), instantiated twice.

Verification
REQ-031 SHALL verify reset lock-in: after reset, patterns 01,02,03, each held 3 sample_en cycles -> valid_o x3, locked=1 after 02, no errors.
REQ-032 SHALL verify wrap-around: locked at 98, then 99 followed by 01 -> valid_o each, no seq_err; 99 followed by 00 -> seq_err, err_cnt=1, locked=0.
REQ-033 SHALL verify glitch rejection: a 1-sample glitch to 55 between stable 10 and 11 (STABLE_N=2) -> 55 is never accepted and 11 is accepted without seq_err.
REQ-034 SHALL verify illegal patterns: ones=0000001 held stable -> one pat_err, tens_o/ones_o hold the prior value, state UNLOCKED.
REQ-035 SHALL verify error-count saturation: 260 alternating illegal/legal stable values -> err_cnt=255.
REQ-036 SHALL verify reset mid-stream: assert rst while locked at 42 -> all outputs 0, and next stable 43 gives valid_o with locked=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment sequence monitor: segment patterns,
// FSM state encoding, STABLE_N limits and the BCD successor helper.
package seg7_pkg;

  // bit6..0 = g..a, active-high
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  localparam int unsigned STABLE_MIN = 1;
  localparam int unsigned STABLE_MAX = 15;

  typedef logic [1:0] state_t;
  localparam state_t ST_UNLOCKED = 2'd0;
  localparam state_t ST_ACQUIRE  = 2'd1;
  localparam state_t ST_LOCKED   = 2'd2;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // 99 wraps to 01, so 00 is never produced as an expected value
  function automatic bcd2_t bcd_succ(input bcd2_t v);
    bcd2_t n;
    if (v.tens == 4'd9 && v.ones == 4'd9) begin
      n.tens = 4'd0;
      n.ones = 4'd1;
    end else if (v.ones == 4'd9) begin
      n.tens = v.tens + 4'd1;
      n.ones = 4'd0;
    end else begin
      n.tens = v.tens;
      n.ones = v.ones + 4'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment to BCD decoder; unknown patterns flag illegal.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       illegal
);

  always_comb begin
    digit   = 4'd0;
    illegal = 1'b0;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_seq_monitor.sv
// Debounces a two-digit 7-segment display, decodes accepted values and
// checks that they count up by one (BCD, 99 -> 01) once locked.
module seg7_seq_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic [6:0] seg_tens,
  input  logic [6:0] seg_ones,
  output logic       valid_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       pat_err,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] err_cnt
);

  if (STABLE_N < STABLE_MIN || STABLE_N > STABLE_MAX) begin : g_bad_stable_n
    $error("seg7_seq_monitor: STABLE_N out of range");
  end

  localparam logic [3:0] STABLE_W = 4'(STABLE_N);

  logic [13:0] r_prev;
  logic [13:0] r_last;
  logic [3:0]  r_cnt;
  logic        r_none;
  state_t      r_state;
  bcd2_t       r_exp;

  logic [13:0] w_sample;
  logic [3:0]  w_cnt_nxt;
  logic        w_accept;
  logic [3:0]  w_tens_d;
  logic [3:0]  w_ones_d;
  logic        w_ill_tens;
  logic        w_ill_ones;
  logic        w_illegal;
  bcd2_t       w_val;
  logic        w_match;
  logic        w_seq_bad;
  logic        w_err_evt;

  seg7_decode u_dec_tens (.seg(seg_tens), .digit(w_tens_d), .illegal(w_ill_tens));
  seg7_decode u_dec_ones (.seg(seg_ones), .digit(w_ones_d), .illegal(w_ill_ones));

  assign w_sample  = {seg_tens, seg_ones};
  assign w_cnt_nxt = (w_sample != r_prev) ? 4'd1 :
                     (r_cnt >= STABLE_W)  ? STABLE_W : r_cnt + 4'd1;
  // raw-pattern compare against the last accepted value blocks re-acceptance of a held value
  assign w_accept  = sample_en && (w_cnt_nxt == STABLE_W) && (r_none || w_sample != r_last);
  assign w_illegal = w_ill_tens | w_ill_ones;
  assign w_val     = '{tens: w_tens_d, ones: w_ones_d};
  assign w_match   = (w_val == r_exp);
  assign w_seq_bad = !w_illegal && (r_state == ST_LOCKED) && !w_match;
  assign w_err_evt = w_accept && (w_illegal || w_seq_bad);
  assign locked    = (r_state == ST_LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
      r_none  <= 1'b1;
      r_state <= ST_UNLOCKED;
      r_exp   <= '0;
      valid_o <= 1'b0;
      pat_err <= 1'b0;
      seq_err <= 1'b0;
      tens_o  <= '0;
      ones_o  <= '0;
      err_cnt <= '0;
    end else begin
      valid_o <= 1'b0;
      pat_err <= 1'b0;
      seq_err <= 1'b0;
      if (sample_en) begin
        r_prev <= w_sample;
        r_cnt  <= w_cnt_nxt;
      end
      if (w_err_evt && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (w_accept) begin
        r_last <= w_sample;
        r_none <= 1'b0;
        if (w_illegal) begin
          pat_err <= 1'b1;
          r_state <= ST_UNLOCKED;
        end else begin
          valid_o <= 1'b1;
          tens_o  <= w_tens_d;
          ones_o  <= w_ones_d;
          r_exp   <= bcd_succ(w_val);
          case (r_state)
            ST_UNLOCKED: r_state <= ST_ACQUIRE;
            ST_ACQUIRE:  if (w_match) r_state <= ST_LOCKED;
            ST_LOCKED: begin
              if (!w_match) begin
                seq_err <= 1'b1;
                r_state <= ST_ACQUIRE;
              end
            end
            default:     r_state <= ST_UNLOCKED;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_seq_monitor.sv
// Directed vector bench for seg7_seq_monitor (STABLE_N = 2).
module tb_seg7_seq_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic       valid_o;
  logic [3:0] tens_o;
  logic [3:0] ones_o;
  logic       pat_err;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  seg7_seq_monitor #(.STABLE_N(2)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .seg_tens(seg_tens), .seg_ones(seg_ones),
    .valid_o(valid_o), .tens_o(tens_o), .ones_o(ones_o),
    .pat_err(pat_err), .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        en;
    logic [6:0]  tp;
    logic [6:0]  op;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [6:0] BAD = 7'b0000001;

  function automatic logic [6:0] sp(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [19:0] obs();
    return {valid_o, pat_err, seq_err, locked, tens_o, ones_o, err_cnt};
  endfunction

  // expected = {valid, pat_err, seq_err, locked, tens, ones, err_cnt}
  task automatic add(input logic r, input logic en, input logic [6:0] tp, input logic [6:0] op,
                     input logic v, input logic pe, input logic se, input logic lk,
                     input int t, input int o, input int ec);
    vec_t x;
    x.r = r; x.en = en; x.tp = tp; x.op = op;
    x.exp = {v, pe, se, lk, 4'(t), 4'(o), 8'(ec)};
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v/pe/se/lk=%b%b%b%b %0d%0d cnt=%0d, want v/pe/se/lk=%b%b%b%b %0d%0d cnt=%0d",
               name, act[19], act[18], act[17], act[16], act[15:12], act[11:8], act[7:0],
               exp[19], exp[18], exp[17], exp[16], exp[15:12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic [6:0] tp, input logic [6:0] op);
    rst = r; sample_en = en; seg_tens = tp; seg_ones = op;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; seg_tens = '0; seg_ones = '0;

    // lock-in 01,02,03 held 3 samples each, then sample_en low holds everything
    add(1,0,'0,'0,        0,0,0,0, 0,0, 0);
    add(0,1,sp(0),sp(1),  0,0,0,0, 0,0, 0);
    add(0,1,sp(0),sp(1),  1,0,0,0, 0,1, 0);
    add(0,1,sp(0),sp(1),  0,0,0,0, 0,1, 0);
    add(0,1,sp(0),sp(2),  0,0,0,0, 0,1, 0);
    add(0,1,sp(0),sp(2),  1,0,0,1, 0,2, 0);
    add(0,1,sp(0),sp(2),  0,0,0,1, 0,2, 0);
    add(0,1,sp(0),sp(3),  0,0,0,1, 0,2, 0);
    add(0,1,sp(0),sp(3),  1,0,0,1, 0,3, 0);
    add(0,1,sp(0),sp(3),  0,0,0,1, 0,3, 0);
    add(0,0,sp(5),sp(5),  0,0,0,1, 0,3, 0);
    add(0,0,sp(5),sp(5),  0,0,0,1, 0,3, 0);
    // wrap 98,99,01 stays locked
    add(1,0,'0,'0,        0,0,0,0, 0,0, 0);
    add(0,1,sp(9),sp(7),  0,0,0,0, 0,0, 0);
    add(0,1,sp(9),sp(7),  1,0,0,0, 9,7, 0);
    add(0,1,sp(9),sp(8),  0,0,0,0, 9,7, 0);
    add(0,1,sp(9),sp(8),  1,0,0,1, 9,8, 0);
    add(0,1,sp(9),sp(9),  0,0,0,1, 9,8, 0);
    add(0,1,sp(9),sp(9),  1,0,0,1, 9,9, 0);
    add(0,1,sp(0),sp(1),  0,0,0,1, 9,9, 0);
    add(0,1,sp(0),sp(1),  1,0,0,1, 0,1, 0);
    // 99 then 00 is out of sequence
    add(1,0,'0,'0,        0,0,0,0, 0,0, 0);
    add(0,1,sp(9),sp(8),  0,0,0,0, 0,0, 0);
    add(0,1,sp(9),sp(8),  1,0,0,0, 9,8, 0);
    add(0,1,sp(9),sp(9),  0,0,0,0, 9,8, 0);
    add(0,1,sp(9),sp(9),  1,0,0,1, 9,9, 0);
    add(0,1,sp(0),sp(0),  0,0,0,1, 9,9, 0);
    add(0,1,sp(0),sp(0),  1,0,1,0, 0,0, 1);
    // one-sample glitch to 55 between locked 10 and 11
    add(1,0,'0,'0,        0,0,0,0, 0,0, 0);
    add(0,1,sp(0),sp(9),  0,0,0,0, 0,0, 0);
    add(0,1,sp(0),sp(9),  1,0,0,0, 0,9, 0);
    add(0,1,sp(1),sp(0),  0,0,0,0, 0,9, 0);
    add(0,1,sp(1),sp(0),  1,0,0,1, 1,0, 0);
    add(0,1,sp(5),sp(5),  0,0,0,1, 1,0, 0);
    add(0,1,sp(1),sp(1),  0,0,0,1, 1,0, 0);
    add(0,1,sp(1),sp(1),  1,0,0,1, 1,1, 0);
    // illegal ones pattern: pat_err, digits hold, back to UNLOCKED
    add(0,1,sp(1),BAD,    0,0,0,1, 1,1, 0);
    add(0,1,sp(1),BAD,    0,1,0,0, 1,1, 1);
    add(0,1,sp(1),BAD,    0,0,0,0, 1,1, 1);
    add(0,1,sp(1),sp(2),  0,0,0,0, 1,1, 1);
    add(0,1,sp(1),sp(2),  1,0,0,0, 1,2, 1);
    add(0,1,sp(1),sp(3),  0,0,0,0, 1,2, 1);
    add(0,1,sp(1),sp(3),  1,0,0,1, 1,3, 1);
    // reset while locked at 42, then 43 restarts acquisition
    add(1,0,'0,'0,        0,0,0,0, 0,0, 0);
    add(0,1,sp(4),sp(1),  0,0,0,0, 0,0, 0);
    add(0,1,sp(4),sp(1),  1,0,0,0, 4,1, 0);
    add(0,1,sp(4),sp(2),  0,0,0,0, 4,1, 0);
    add(0,1,sp(4),sp(2),  1,0,0,1, 4,2, 0);
    add(1,0,sp(4),sp(2),  0,0,0,0, 0,0, 0);
    add(0,1,sp(4),sp(3),  0,0,0,0, 0,0, 0);
    add(0,1,sp(4),sp(3),  1,0,0,0, 4,3, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].en, vecs[i].tp, vecs[i].op);
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // saturation: 260 illegal values, each followed by legal 00
    drive(1, 0, '0, '0);
    for (int i = 0; i < 260; i++) begin
      logic [19:0] a;
      logic [19:0] e;
      int ec;
      ec = (i + 1 > 255) ? 255 : i + 1;
      drive(0, 1, sp(0), BAD);
      drive(0, 1, sp(0), BAD);
      a = obs();
      e = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'(ec)};
      check($sformatf("sat%0d", i), a, e);
      drive(0, 1, sp(0), sp(0));
      drive(0, 1, sp(0), sp(0));
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_final: err_cnt=%0d want 255", err_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
